// File: rtl/l1c_pkg.sv
// Shared types, access-size encodings and width helpers for the set-associative L1 data cache.
package l1c_pkg;

  localparam logic [2:0] CACHE_BYTE  = 3'b000;
  localparam logic [2:0] CACHE_HWORD = 3'b001;
  localparam logic [2:0] CACHE_WORD  = 3'b010;

  typedef enum logic [2:0] {
    IDLE,
    CHK,
    RMISS,
    RFILL_DONE,
    WRITE
  } state_t;

  function automatic int off_bits(input int line_words);
    return $clog2(line_words) + 2;
  endfunction

  function automatic int ptr_bits(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

  // Unlisted access types fall through to a full-word enable.
  function automatic logic [3:0] byte_en(input logic [2:0] t, input logic [1:0] a);
    case (t)
      CACHE_BYTE:  byte_en = 4'b0001 << a;
      CACHE_HWORD: byte_en = a[1] ? 4'b1100 : 4'b0011;
      default:     byte_en = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input logic [2:0] t, input logic [31:0] d);
    case (t)
      CACHE_BYTE:  lane_data = {4{d[7:0]}};
      CACHE_HWORD: lane_data = {2{d[15:0]}};
      default:     lane_data = d;
    endcase
  endfunction

endpackage

// File: rtl/l1c_way_array.sv
// One cache way: valid/tag/data per set, synchronous fill or byte-enabled word write, combinational read.
module l1c_way_array #(
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = 22,
  parameter int LINE_WORDS = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [INDEX_BITS-1:0]      idx,
  output logic                       rd_valid,
  output logic [TAG_BITS-1:0]        rd_tag,
  output logic [LINE_WORDS*32-1:0]   rd_line,
  input  logic                       fill_en,
  input  logic [TAG_BITS-1:0]        fill_tag,
  input  logic [LINE_WORDS*32-1:0]   fill_line,
  input  logic                       wr_en,
  input  logic [$clog2(LINE_WORDS)-1:0] wr_word,
  input  logic [3:0]                 wr_be,
  input  logic [31:0]                wr_data
);
  localparam int SETS = 2 ** INDEX_BITS;

  logic [SETS-1:0]            valid_q;
  logic [TAG_BITS-1:0]        tag_q  [SETS];
  logic [LINE_WORDS*32-1:0]   data_q [SETS];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (fill_en) begin
      valid_q[idx] <= 1'b1;
      tag_q[idx]   <= fill_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      data_q[idx] <= fill_line;
    end else if (wr_en) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (wr_be[b]) data_q[idx][int'(wr_word)*32 + int'(b)*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

  assign rd_valid = valid_q[idx];
  assign rd_tag   = tag_q[idx];
  assign rd_line  = data_q[idx];

endmodule

// File: rtl/l1c_data_sa.sv
// Set-associative write-through / no-write-allocate L1 data cache with per-set round-robin replacement.
// Optional L1C_STATS_EN adds saturating hit_cnt / miss_cnt outputs.
module l1c_data_sa
  import l1c_pkg::*;
#(
  parameter int WAYS       = 2,
  parameter int INDEX_BITS = 6,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_req,
  input  logic        core_write,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_in,
  input  logic [2:0]  core_type,
  output logic [31:0] core_out,
  output logic        core_wait,
  output logic        D_req,
  output logic        D_write,
  output logic [31:0] D_addr,
  output logic [31:0] D_in,
  output logic [2:0]  D_type,
  input  logic [31:0] D_out,
  input  logic        D_wait
`ifdef L1C_STATS_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);
  localparam int OFF_BITS  = off_bits(LINE_WORDS);
  localparam int TAG_BITS  = 32 - INDEX_BITS - OFF_BITS;
  localparam int WORD_BITS = OFF_BITS - 2;
  localparam int PTR_BITS  = ptr_bits(WAYS);
  localparam int SETS      = 2 ** INDEX_BITS;
  localparam int LINE_BITS = LINE_WORDS * 32;

  state_t state, state_nx;

  logic [31:0]                  lat_addr, lat_data;
  logic                         lat_write;
  logic [2:0]                   lat_type;
  logic [WORD_BITS-1:0]         beat_q;
  logic [LINE_BITS-1:0]         rbuf;
  logic [SETS-1:0][PTR_BITS-1:0] rr_q;

  logic [TAG_BITS-1:0]   lat_tag;
  logic [INDEX_BITS-1:0] lat_idx;
  logic [WORD_BITS-1:0]  lat_word;
  assign lat_tag  = lat_addr[31 -: TAG_BITS];
  assign lat_idx  = lat_addr[OFF_BITS +: INDEX_BITS];
  assign lat_word = lat_addr[2 +: WORD_BITS];

  logic [WAYS-1:0]       way_valid, fill_en, wr_en;
  logic [TAG_BITS-1:0]   way_tag  [WAYS];
  logic [LINE_BITS-1:0]  way_line [WAYS];

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    l1c_way_array #(
      .INDEX_BITS(INDEX_BITS),
      .TAG_BITS  (TAG_BITS),
      .LINE_WORDS(LINE_WORDS)
    ) u_way (
      .clk      (clk),
      .rst      (rst),
      .idx      (lat_idx),
      .rd_valid (way_valid[g]),
      .rd_tag   (way_tag[g]),
      .rd_line  (way_line[g]),
      .fill_en  (fill_en[g]),
      .fill_tag (lat_tag),
      .fill_line(rbuf),
      .wr_en    (wr_en[g]),
      .wr_word  (lat_word),
      .wr_be    (byte_en(lat_type, lat_addr[1:0])),
      .wr_data  (lane_data(lat_type, lat_data))
    );
  end

  logic                hit, found_inv;
  logic [PTR_BITS-1:0] hit_way, victim;

  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    found_inv = 1'b0;
    victim    = rr_q[lat_idx];
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!hit && way_valid[w] && way_tag[w] == lat_tag) begin
        hit     = 1'b1;
        hit_way = PTR_BITS'(w);
      end
      if (!found_inv && !way_valid[w]) begin
        found_inv = 1'b1;
        victim    = PTR_BITS'(w);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:       if (core_req) state_nx = CHK;
      CHK:        state_nx = lat_write ? WRITE : (hit ? IDLE : RMISS);
      RMISS:      if (!D_wait && beat_q == WORD_BITS'(LINE_WORDS - 1)) state_nx = RFILL_DONE;
      RFILL_DONE: state_nx = IDLE;
      WRITE:      if (!D_wait) state_nx = IDLE;
      default:    state_nx = IDLE;
    endcase
  end

  always_comb begin
    core_wait = (state != IDLE) || core_req;
    core_out  = '0;
    D_req     = 1'b0;
    D_write   = 1'b0;
    D_addr    = '0;
    D_in      = '0;
    D_type    = '0;
    fill_en   = '0;
    wr_en     = '0;
    case (state)
      CHK: begin
        if (!lat_write && hit) begin
          core_wait = 1'b0;
          core_out  = way_line[hit_way][int'(lat_word)*32 +: 32];
        end
        if (lat_write && hit) wr_en[hit_way] = 1'b1;
      end
      RMISS: begin
        D_req  = 1'b1;
        D_addr = {lat_tag, lat_idx, {OFF_BITS{1'b0}}};
      end
      RFILL_DONE: begin
        core_wait       = 1'b0;
        core_out        = rbuf[int'(lat_word)*32 +: 32];
        fill_en[victim] = 1'b1;
      end
      WRITE: begin
        D_req   = 1'b1;
        D_write = 1'b1;
        D_addr  = lat_addr;
        D_in    = lat_data;
        D_type  = lat_type;
        if (!D_wait) core_wait = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lat_addr  <= '0;
      lat_data  <= '0;
      lat_write <= 1'b0;
      lat_type  <= '0;
      beat_q    <= '0;
      rbuf      <= '0;
      rr_q      <= '0;
    end else begin
      if (state == IDLE && core_req) begin
        lat_addr  <= core_addr;
        lat_data  <= core_in;
        lat_write <= core_write;
        lat_type  <= core_type;
        beat_q    <= '0;
      end
      if (state == RMISS && !D_wait) begin
        rbuf[int'(beat_q)*32 +: 32] <= D_out;
        beat_q <= beat_q + 1'b1;
      end
      // Pointer advances on every refill, whether the victim was invalid or round-robin.
      if (state == RFILL_DONE) begin
        rr_q[lat_idx] <= (int'(rr_q[lat_idx]) == WAYS - 1) ? '0 : rr_q[lat_idx] + 1'b1;
      end
    end
  end

`ifdef L1C_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state == CHK) begin
      if (hit && hit_cnt != '1)        hit_cnt  <= hit_cnt + 1'b1;
      else if (!hit && miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
    end
  end
`endif

endmodule
